// File: rtl/uart_pixel_writer.sv
// UART byte stream to frame-buffer pixel writer with end-of-frame and idle-timeout resync.
// Define PIXEL_PACK_EN to pack two 3-bit pixels per byte (bits [2:0] then [6:4]).
//
// state  | meaning
// S_IDLE | waiting for the first pixel of a frame, write_addr = 0
// S_RECV | frame in progress, idle timer running
// S_DONE | last pixel written, frame_done pulses, then back to S_IDLE
// S_WR2  | (PIXEL_PACK_EN only) writing the second pixel of a packed byte
module uart_pixel_writer #(
   parameter int IMG_W       = 160,
   parameter int IMG_H       = 120,
   parameter int ADDR_W      = 15,
   parameter int TIMEOUT_CYC = 5_000_000
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic              uart_valid,
   input  logic [7:0]        uart_data,
   input  logic              frame_error,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_wdata,
   output logic [ADDR_W-1:0] write_addr,
   output logic              frame_done,
   output logic              timeout,
   output logic [7:0]        drop_cnt,
   output logic              busy
);

   localparam int                CNT_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [CNT_W-1:0]  CNT_TC    = CNT_W'(TIMEOUT_CYC - 1);

`ifdef PIXEL_PACK_EN
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_WR2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [2:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              frame_done_q, frame_done_d;
   logic              timeout_q, timeout_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fmt_ok, take, drop;
`ifdef PIXEL_PACK_EN
   logic [2:0]        pix2_q, pix2_d;
`endif

`ifdef PIXEL_PACK_EN
   assign fmt_ok = ~uart_data[7] & ~uart_data[3];
`else
   assign fmt_ok = (uart_data[7:3] == 5'd0);
`endif
   // Bytes arriving while a write or frame_done is pending are dropped, not queued.
   assign take = uart_valid & ~frame_error & fmt_ok & ((state_q == S_IDLE) | (state_q == S_RECV));
   assign drop = uart_valid & ~take;

   always_comb begin
      state_d      = state_q;
      write_addr_d = write_addr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      cnt_d        = cnt_q;
`ifdef PIXEL_PACK_EN
      pix2_d       = pix2_q;
`endif

      if (drop && drop_cnt_q != 8'hFF)
         drop_cnt_d = drop_cnt_q + 8'd1;

      case (state_q)
         S_IDLE, S_RECV: begin
            if (take) begin
               cnt_d       = '0;
               mem_we_d    = 1'b1;
               mem_addr_d  = write_addr_q;
               mem_wdata_d = uart_data[2:0];
`ifdef PIXEL_PACK_EN
               pix2_d       = uart_data[6:4];
               write_addr_d = write_addr_q + ADDR_W'(1);
               state_d      = S_WR2;
`else
               if (write_addr_q == LAST_ADDR) begin
                  write_addr_d = '0;
                  state_d      = S_DONE;
               end else begin
                  write_addr_d = write_addr_q + ADDR_W'(1);
                  state_d      = S_RECV;
               end
`endif
            end else if (state_q == S_RECV) begin
               // An accepted byte on the expiry edge takes the branch above instead.
               if (cnt_q == CNT_TC) begin
                  timeout_d    = 1'b1;
                  write_addr_d = '0;
                  cnt_d        = '0;
                  state_d      = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
         end
`ifdef PIXEL_PACK_EN
         S_WR2: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = write_addr_q;
            mem_wdata_d = pix2_q;
            if (write_addr_q == LAST_ADDR) begin
               write_addr_d = '0;
               state_d      = S_DONE;
            end else begin
               write_addr_d = write_addr_q + ADDR_W'(1);
               state_d      = S_RECV;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      busy_d = (write_addr_d != '0);
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q      <= S_IDLE;
         write_addr_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         drop_cnt_q   <= '0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
`ifdef PIXEL_PACK_EN
         pix2_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         write_addr_q <= write_addr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
         drop_cnt_q   <= drop_cnt_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
`ifdef PIXEL_PACK_EN
         pix2_q       <= pix2_d;
`endif
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign write_addr = write_addr_q;
   assign frame_done = frame_done_q;
   assign timeout    = timeout_q;
   assign drop_cnt   = drop_cnt_q;
   assign busy       = busy_q;

endmodule

// File: doc/uart_pixel_writer.md
Name: uart_pixel_writer

Overview:
- Sits directly downstream of the UART receiver inside fpga_top; consumes each received byte (uart_data, uart_valid, frame_error).
- Converts accepted bytes into 3-bit RGB pixels and writes them sequentially into the frame-buffer RAM write port.
- Owns write_addr, detects end of frame, and resynchronises on an inter-byte timeout.
- Drops malformed bytes and counts them for LED debug.

Parameters:
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame.
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- TIMEOUT_CYC, 5_000_000, idle clock cycles mid-frame before resync (100 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- rst  in  1  synchronous, active-high reset (driven from por_rst).
- uart_valid  in  1  one-cycle pulse: uart_data holds a new byte.
- uart_data  in  8  received byte.
- frame_error  in  1  stop-bit error for the byte flagged this cycle.
- mem_we  out  1  frame-buffer write enable.
- mem_addr  out  ADDR_W  frame-buffer write address.
- mem_wdata  out  3  pixel {R,G,B}.
- write_addr  out  ADDR_W  next pixel address to be written.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- timeout  out  1  one-cycle pulse when a partial frame is abandoned.
- drop_cnt  out  8  saturating count of dropped bytes.
- busy  out  1  high while a frame is in progress (write_addr != 0).

Behaviour:
- Reset (synchronous, rst=1 on a CLOCK_50 edge): all outputs 0, state S_IDLE, timeout counter 0. Reset mid-frame discards the partial frame; there are no RAM writes during reset.
- A byte is accepted when uart_valid=1, frame_error=0 and uart_data[7:3]==0.
- A byte is dropped when uart_valid=1 and (frame_error=1 or uart_data[7:3]!=0). A drop increments drop_cnt, which saturates at 255, and causes no write. A drop does not reset the timeout counter.
- Write latency: accepted byte at edge N -> at N+1 mem_we=1, mem_addr=write_addr(old), mem_wdata=uart_data[2:0]; write_addr increments in the same cycle. mem_we is otherwise 0.
- States:
  - S_IDLE: write_addr=0, busy=0. Accepted byte -> write -> S_RECV.
  - S_RECV: each accepted byte writes the next address. When the written address == IMG_W*IMG_H-1, write_addr wraps to 0 and the state goes to S_DONE.
  - S_DONE: frame_done=1 for exactly one cycle -> S_IDLE. A uart_valid arriving in S_DONE is dropped and counted.
- Timeout:
  - The counter runs only in S_RECV and clears on every accepted byte.
  - On reaching TIMEOUT_CYC-1: timeout pulses for 1 cycle, write_addr<=0, state -> S_IDLE. Already-written RAM contents are kept.
- Simultaneous events: if an accepted byte arrives on the same edge as timeout expiry, the byte wins (it is written, the counter clears, no timeout).
- The block never back-pressures; the UART byte spacing (>=5000 cycles) guarantees no overlap.

Optional Feature:
- Macro PIXEL_PACK_EN.
- Defined:
  - Each accepted byte carries two pixels: first uart_data[2:0], second uart_data[6:4].
  - Acceptance requires uart_data[7]==0 and uart_data[3]==0; otherwise the byte is dropped.
  - Added state S_WR2: edge N+1 writes the first pixel at addr A; edge N+2 writes the second at A+1; write_addr advances by 2.
  - A uart_valid during S_WR2 is dropped and counted.
  - IMG_W*IMG_H must be even. The frame ends when the second pixel lands on IMG_W*IMG_H-1.
- Undefined: one pixel per byte as above; S_WR2 does not exist.

Test Plan:
- IMG_W=4, IMG_H=2; send 0x00..0x07 -> writes (addr,data) (0,0)..(7,7); frame_done pulses once after the 8th write; write_addr=0; drop_cnt=0.
- Send 0xAA, 0x55, 0xFF, then 0x03 -> the first three are dropped (drop_cnt=3) and 0x03 writes addr 0 data 3; drop saturation check: 300 bad bytes -> drop_cnt=255.
- Inject frame_error=1 with uart_valid carrying 0x05 -> no mem_we; drop_cnt+1; write_addr unchanged.
- TIMEOUT_CYC=1000; send 3 valid bytes, then idle 1000 cycles -> timeout pulses once, write_addr=0, state S_IDLE; the next byte 0x02 writes addr 0.
- Assert rst for one cycle after 5 bytes -> all outputs 0 on the next cycle; the next byte writes addr 0.
- PIXEL_PACK_EN defined, IMG_W=4, IMG_H=2; send 0x10, 0x32, 0x54, 0x76 -> writes (0,0),(1,1),(2,2),(3,3),(4,4),(5,5),(6,6),(7,7); frame_done pulses once; 0x18 is dropped.
